// File: rtl/sram_arbiter_ctrl.sv
// SSRAM sequencer and two-port arbiter (CPU read/write, synth DMA read-only).
// Runs a request/acknowledge FSM on the system clock. The synth port has
// priority, but the CPU is guaranteed a grant after STARVE_LIMIT consecutive
// synth grants. Every output except oSRAM_CLK and the DQ tristate is a flop.
module sram_arbiter_ctrl #(
    parameter logic [31:0] BEGINNING_SRAM = 32'h1000_0000,
    parameter logic [31:0] END_SRAM       = 32'h101F_FFFF,
    parameter int          READ_LAT       = 2,
    parameter int          STARVE_LIMIT   = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCpuReq,
    input  logic        iCpuWrite,
    input  logic [3:0]  iCpuBE,
    input  logic [31:0] iCpuAddr,
    input  logic [31:0] iCpuWData,
    output logic        oCpuAck,
    output logic [31:0] oCpuRData,
    input  logic        iSynReq,
    input  logic [31:0] iSynAddr,
    output logic        oSynAck,
    output logic [31:0] oSynRData,
    inout  wire  [31:0] SRAM_DQ,
    output logic [18:0] oSRAM_A,
    output logic        oSRAM_ADSP_N,
    output logic        oSRAM_WE_N,
    output logic [3:0]  oSRAM_BE_N,
    output logic        oSRAM_OE_N,
    output logic        oSRAM_CLK
);

    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W = 2;
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              win_syn_r;
    logic              wr_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic [31:0]       dq_out_r;
    logic              dq_oe_r;

    logic              cpu_grant_s;
    logic              syn_grant_s;
    logic [31:0]       sel_addr_s;
    logic              sel_write_s;

    // True when the full 32-bit byte address falls inside the SSRAM window.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr >= BEGINNING_SRAM) && (addr <= END_SRAM);
    endfunction

    assign oSRAM_CLK = iCLK;
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 32'hzzzz_zzzz;

    // Arbitration: synth first, unless the CPU has waited STARVE_LIMIT grants.
    always_comb begin
        cpu_grant_s = 1'b0;
        syn_grant_s = 1'b0;
        if (iCpuReq && (starve_cnt_r == STARVE_MAX)) begin
            cpu_grant_s = 1'b1;
        end else if (iSynReq) begin
            syn_grant_s = 1'b1;
        end else if (iCpuReq) begin
            cpu_grant_s = 1'b1;
        end else begin
            cpu_grant_s = 1'b0;
            syn_grant_s = 1'b0;
        end
        sel_addr_s  = syn_grant_s ? iSynAddr : iCpuAddr;
        sel_write_s = cpu_grant_s & iCpuWrite;
    end

    // Main FSM: latches the winner, sequences SSRAM pins, captures data, acks.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r      <= IDLE;
            win_syn_r    <= 1'b0;
            wr_r         <= 1'b0;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            starve_cnt_r <= {CNT_W{1'b0}};
            dq_out_r     <= 32'h0000_0000;
            dq_oe_r      <= 1'b0;
            oCpuAck      <= 1'b0;
            oSynAck      <= 1'b0;
            oCpuRData    <= 32'h0000_0000;
            oSynRData    <= 32'h0000_0000;
            oSRAM_A      <= 19'h0_0000;
            oSRAM_ADSP_N <= 1'b1;
            oSRAM_WE_N   <= 1'b1;
            oSRAM_BE_N   <= 4'hF;
            oSRAM_OE_N   <= 1'b1;
        end else begin
            // Acks are single-cycle pulses unless a state below raises them.
            oCpuAck <= 1'b0;
            oSynAck <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cpu_grant_s || syn_grant_s) begin
                        win_syn_r    <= syn_grant_s;
                        wr_r         <= sel_write_s;
                        starve_cnt_r <= (syn_grant_s && iCpuReq) ?
                                        (starve_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
                        if (addr_in_range(sel_addr_s)) begin
                            state_r      <= ISSUE;
                            oSRAM_A      <= sel_addr_s[20:2];
                            oSRAM_ADSP_N <= 1'b0;
                            if (sel_write_s) begin
                                oSRAM_WE_N <= 1'b0;
                                oSRAM_BE_N <= ~iCpuBE;
                                oSRAM_OE_N <= 1'b1;
                                dq_out_r   <= iCpuWData;
                                dq_oe_r    <= 1'b1;
                            end else begin
                                oSRAM_WE_N <= 1'b1;
                                oSRAM_BE_N <= 4'h0;
                                oSRAM_OE_N <= 1'b0;
                                dq_oe_r    <= 1'b0;
                            end
                        end else begin
                            // Unmapped address: answer immediately, never touch the pins.
                            state_r <= DONE;
                            if (syn_grant_s) begin
                                oSynAck   <= 1'b1;
                                oSynRData <= 32'h0000_0000;
                            end else begin
                                oCpuAck <= 1'b1;
                                if (!sel_write_s) begin
                                    oCpuRData <= 32'h0000_0000;
                                end else begin
                                    oCpuRData <= oCpuRData;
                                end
                            end
                        end
                    end else begin
                        state_r      <= IDLE;
                        starve_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ISSUE: begin
                    oSRAM_ADSP_N <= 1'b1;
                    if (wr_r) begin
                        // Write data is on DQ for the ISSUE cycle only.
                        oSRAM_WE_N <= 1'b1;
                        oSRAM_BE_N <= 4'hF;
                        dq_oe_r    <= 1'b0;
                        state_r    <= DONE;
                        oCpuAck    <= ~win_syn_r;
                        oSynAck    <= win_syn_r;
                    end else begin
                        wait_cnt_r <= WAIT_INIT;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                        oSRAM_OE_N <= 1'b1;
                        oSRAM_BE_N <= 4'hF;
                        state_r    <= DONE;
                        if (win_syn_r) begin
                            oSynRData <= SRAM_DQ;
                            oSynAck   <= 1'b1;
                        end else begin
                            oCpuRData <= SRAM_DQ;
                            oCpuAck   <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    dq_oe_r      <= 1'b0;
                    oSRAM_ADSP_N <= 1'b1;
                    oSRAM_WE_N   <= 1'b1;
                    oSRAM_BE_N   <= 4'hF;
                    oSRAM_OE_N   <= 1'b1;
                end
            endcase
        end
    end

endmodule
